// File: rtl/conv_tap_accumulator.sv
// Tap sequencer and accumulator for the 3x3 convolution datapath: steps the product
// mux select, sums the signed products at full precision and hands off one result per window.
module conv_tap_accumulator #(
  parameter int WIDTH     = 14,
  parameter int NTAPS     = 9,
  parameter int ACC_WIDTH = 18
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  output logic                 busy,
  output logic [3:0]           mux_sel,
  input  logic [WIDTH-1:0]     in_adder,
  input  logic                 in_adder_valid,
  output logic [ACC_WIDTH-1:0] sum_out,
  output logic [7:0]           pix_out,
  output logic                 sum_valid,
  input  logic                 sum_ready
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [3:0] SEL_IDLE = 4'd9;
  localparam logic [3:0] SEL_LAST = 4'(NTAPS - 1);

  state_t               state_r;
  state_t               next_state_s;
  logic [ACC_WIDTH-1:0] acc_r;
  logic [ACC_WIDTH-1:0] sum_next_s;
  logic                 clear_s;
  logic                 add_s;
  logic                 finish_s;
  logic                 release_s;

  // Negative results clamp to 0 and anything above 255 saturates.
  function automatic logic [7:0] clamp_pix(input logic [ACC_WIDTH-1:0] v);
    if (v[ACC_WIDTH-1]) begin
      clamp_pix = 8'd0;
    end else if (|v[ACC_WIDTH-2:8]) begin
      clamp_pix = 8'd255;
    end else begin
      clamp_pix = v[7:0];
    end
  endfunction

  assign sum_next_s = acc_r + {{(ACC_WIDTH-WIDTH){in_adder[WIDTH-1]}}, in_adder};

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state and datapath control decode.
  always_comb begin
    next_state_s = state_r;
    clear_s      = 1'b0;
    add_s        = 1'b0;
    finish_s     = 1'b0;
    release_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          next_state_s = ACCUM;
          clear_s      = 1'b1;
        end else begin
          next_state_s = IDLE;
        end
      end
      ACCUM: begin
        if (in_adder_valid) begin
          add_s = 1'b1;
          if (mux_sel == SEL_LAST) begin
            finish_s     = 1'b1;
            next_state_s = DONE;
          end else begin
            next_state_s = ACCUM;
          end
        end else begin
          next_state_s = ACCUM;
        end
      end
      DONE: begin
        if (sum_ready) begin
          release_s = 1'b1;
          if (start) begin
            next_state_s = ACCUM;
            clear_s      = 1'b1;
          end else begin
            next_state_s = IDLE;
          end
        end else begin
          next_state_s = DONE;
        end
      end
      default: begin
        next_state_s = IDLE;
      end
    endcase
  end

  // Accumulator, tap select and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_r     <= '0;
      mux_sel   <= SEL_IDLE;
      sum_out   <= '0;
      pix_out   <= 8'd0;
      sum_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      busy <= (next_state_s != IDLE);
      if (clear_s) begin
        acc_r   <= '0;
        mux_sel <= 4'd0;
      end else if (finish_s) begin
        acc_r   <= sum_next_s;
        mux_sel <= SEL_IDLE;
        sum_out <= sum_next_s;
        pix_out <= clamp_pix(sum_next_s);
      end else if (add_s) begin
        acc_r   <= sum_next_s;
        mux_sel <= mux_sel + 4'd1;
      end
      if (finish_s) begin
        sum_valid <= 1'b1;
      end else if (release_s) begin
        sum_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_conv_tap_accumulator.sv
// Self-checking bench for conv_tap_accumulator: a behavioural product mux feeds
// per-window product tables; expected sums come from plain integer arithmetic.
module tb_conv_tap_accumulator;

  localparam int WIDTH     = 14;
  localparam int NTAPS     = 9;
  localparam int ACC_WIDTH = 18;

  logic                 clk;
  logic                 rst_n;
  logic                 start;
  logic                 busy;
  logic [3:0]           mux_sel;
  logic [WIDTH-1:0]     in_adder;
  logic                 in_adder_valid;
  logic [ACC_WIDTH-1:0] sum_out;
  logic [7:0]           pix_out;
  logic                 sum_valid;
  logic                 sum_ready;

  int          prod [16];
  logic        valid_en;
  logic [13:0] junk;
  int          tests_run;
  int          tests_failed;

  conv_tap_accumulator #(.WIDTH(WIDTH), .NTAPS(NTAPS), .ACC_WIDTH(ACC_WIDTH)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .busy           (busy),
    .mux_sel        (mux_sel),
    .in_adder       (in_adder),
    .in_adder_valid (in_adder_valid),
    .sum_out        (sum_out),
    .pix_out        (pix_out),
    .sum_valid      (sum_valid),
    .sum_ready      (sum_ready)
  );

  // Product mux: valid only for selects 0..8; stalled beats carry junk data.
  assign in_adder_valid = valid_en && (mux_sel < 4'd9);
  assign in_adder       = in_adder_valid ? 14'(prod[mux_sel]) : junk;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int got, input int exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int sum_s();
    return int'($signed(sum_out));
  endfunction

  // One window: optional start pulse, optional stall, optional result hold, then handshake.
  task automatic run_window(input int hold, input int stall_at, input int stall_len,
                            input bit hold_start, input bit next_start, input bit pre_started);
    int cyc, beats, stall_left, exp_sum, exp_pix;
    exp_sum = 0;
    for (int k = 0; k < NTAPS; k++) exp_sum += prod[k];
    exp_pix = (exp_sum < 0) ? 0 : ((exp_sum > 255) ? 255 : exp_sum);
    if (!pre_started) begin
      start = 1'b1;
      @(posedge clk); #1;
      start = next_start;
    end
    check_eq("sel_first", int'(mux_sel), 0);
    check_eq("busy_accum", int'(busy), 1);
    check_eq("valid_accum", int'(sum_valid), 0);
    beats = 0;
    cyc = 0;
    stall_left = stall_len;
    while (!sum_valid && cyc < 100) begin
      if (stall_left > 0 && beats == stall_at) begin
        valid_en = 1'b0;
        stall_left--;
      end else begin
        valid_en = 1'b1;
      end
      junk = 14'($urandom);
      @(posedge clk); #1;
      cyc++;
      if (valid_en) beats++;
      check_eq("sel_step", int'(mux_sel), (beats < NTAPS) ? beats : 9);
    end
    valid_en = 1'b1;
    check_eq("latency", cyc, NTAPS + stall_len);
    check_eq("sum_out", sum_s(), exp_sum);
    check_eq("pix_out", int'(pix_out), exp_pix);
    check_eq("busy_done", int'(busy), 1);
    for (int h = 0; h < hold; h++) begin
      sum_ready = 1'b0;
      start = hold_start && (h == 1);
      @(posedge clk); #1;
      check_eq("hold_valid", int'(sum_valid), 1);
      check_eq("hold_sum", sum_s(), exp_sum);
      check_eq("hold_pix", int'(pix_out), exp_pix);
      check_eq("hold_busy", int'(busy), 1);
      check_eq("hold_sel", int'(mux_sel), 9);
    end
    sum_ready = 1'b1;
    start = next_start;
    @(posedge clk); #1;
    check_eq("hs_valid", int'(sum_valid), 0);
    check_eq("hs_sel", int'(mux_sel), next_start ? 0 : 9);
    check_eq("hs_busy", int'(busy), next_start ? 1 : 0);
    check_eq("retain_sum", sum_s(), exp_sum);
  endtask

  task automatic load_ramp();
    for (int k = 0; k < NTAPS; k++) prod[k] = 100 * (k + 1);
  endtask

  task automatic load_const(input int v);
    for (int k = 0; k < NTAPS; k++) prod[k] = v;
  endtask

  initial begin
    int mixed [9];
    tests_run = 0;
    tests_failed = 0;
    for (int k = 0; k < 16; k++) prod[k] = 0;
    valid_en = 1'b1;
    junk = 14'd0;
    start = 1'b0;
    sum_ready = 1'b0;
    rst_n = 1'b0;
    #12;
    check_eq("rst_sel", int'(mux_sel), 9);
    check_eq("rst_busy", int'(busy), 0);
    check_eq("rst_valid", int'(sum_valid), 0);
    check_eq("rst_sum", sum_s(), 0);
    check_eq("rst_pix", int'(pix_out), 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Ramp 100..900, sum 4500, clamps to 255.
    load_ramp();
    run_window(0, 0, 0, 1'b0, 1'b0, 1'b0);
    check_eq("sum_4500", sum_s(), 4500);

    load_const(-1000);
    run_window(0, 0, 0, 1'b0, 1'b0, 1'b0);
    check_eq("sum_neg9000", sum_s(), -9000);
    load_const(8191);
    run_window(0, 0, 0, 1'b0, 1'b0, 1'b0);
    check_eq("sum_max", sum_s(), 73719);
    load_const(-8192);
    run_window(0, 0, 0, 1'b0, 1'b0, 1'b0);
    check_eq("sum_min", sum_s(), -73728);

    // Mixed products held for 5 cycles with an ignored start in the hold.
    mixed = '{10, -5, 20, 0, 3, 7, -1, 2, 4};
    for (int k = 0; k < NTAPS; k++) prod[k] = mixed[k];
    run_window(5, 0, 0, 1'b1, 1'b0, 1'b0);
    check_eq("pix_40", int'(pix_out), 40);

    // Three-cycle stall at tap 4.
    load_ramp();
    run_window(0, 4, 3, 1'b0, 1'b0, 1'b0);

    // Back-to-back windows with start and sum_ready held high.
    run_window(0, 0, 0, 1'b0, 1'b1, 1'b0);
    run_window(0, 0, 0, 1'b0, 1'b1, 1'b1);
    run_window(0, 0, 0, 1'b0, 1'b0, 1'b1);

    // Asynchronous reset mid-accumulation.
    load_const(7);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check_eq("pre_rst_sel", int'(mux_sel), 5);
    #2 rst_n = 1'b0;
    #1;
    check_eq("arst_sel", int'(mux_sel), 9);
    check_eq("arst_busy", int'(busy), 0);
    check_eq("arst_valid", int'(sum_valid), 0);
    check_eq("arst_sum", sum_s(), 0);
    check_eq("arst_pix", int'(pix_out), 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    load_ramp();
    run_window(0, 0, 0, 1'b0, 1'b0, 1'b0);
    check_eq("post_rst_sum", sum_s(), 4500);

    // Randomized windows: products, stall point/length and hold length.
    for (int w = 0; w < 8; w++) begin
      for (int k = 0; k < NTAPS; k++) prod[k] = int'($urandom_range(16383)) - 8192;
      if (w == 0) for (int k = 0; k < NTAPS; k++) prod[k] = int'($urandom_range(60));
      run_window(int'($urandom_range(3)), int'($urandom_range(8)), int'($urandom_range(3)),
                 1'($urandom_range(1)), 1'b0, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
